// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the two MEM-stage lanes.
// Same-cycle accesses are serialised lane 0 first, lane 1 one cycle later.
//
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   req0_*, req1_*     per-lane access: valid, we, addr, wdata
//   mem_q              read data from dataMemory (valid in the same cycle)
//   mem_addr/wdata     address and write data to dataMemory
//   mem_wren/rden      memory write / read enables
//   rdata0, rdata1     load results for the lane 0 / lane 1 MEM/WB registers
//   stall              freezes the upstream pipeline for one cycle per conflict
//   conflict_cnt       saturating count of serialised pairs
module dmem_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic [DATA_W-1:0] mem_q,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  output logic              mem_rden,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              stall,
  output logic [CNT_W-1:0]  conflict_cnt
);

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic                hold_we_q;
  logic [ADDR_W-1:0]   hold_addr_q;
  logic [DATA_W-1:0]   hold_wdata_q;
  logic [DATA_W-1:0]   rdata0_hold_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                conflict;

  assign conflict = (state_q == IDLE) & req0_valid & req1_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      hold_we_q     <= 1'b0;
      hold_addr_q   <= '0;
      hold_wdata_q  <= '0;
      rdata0_hold_q <= '0;
      cnt_q         <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (conflict) begin
        hold_we_q     <= req1_we;
        hold_addr_q   <= req1_addr;
        hold_wdata_q  <= req1_wdata;
        rdata0_hold_q <= mem_q;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_addr  = req0_addr;
    mem_wdata = req0_wdata;
    mem_wren  = 1'b0;
    mem_rden  = 1'b0;
    stall     = 1'b0;
    rdata0    = mem_q;
    rdata1    = mem_q;
    unique case (state_q)
      IDLE: begin
        if (req0_valid) begin
          mem_wren = req0_we;
          mem_rden = ~req0_we;
          if (req1_valid) begin
            stall   = 1'b1;
            state_d = SECOND;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (req1_valid) begin
          mem_addr  = req1_addr;
          mem_wdata = req1_wdata;
          mem_wren  = req1_we;
          mem_rden  = ~req1_we;
        end
      end
      SECOND: begin
        // Live requests are ignored here; the pipeline resends nothing new.
        mem_addr  = hold_addr_q;
        mem_wdata = hold_wdata_q;
        mem_wren  = hold_we_q;
        mem_rden  = ~hold_we_q;
        rdata0    = rdata0_hold_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset kills the memory strobes at once, dropping any held lane 1 access.
    if (!rst) begin
      mem_wren = 1'b0;
      mem_rden = 1'b0;
      stall    = 1'b0;
    end
  end

  assign conflict_cnt = cnt_q;

endmodule
